// File: rtl/mdu_if.sv
// Request/response bundle between the control unit and the sequential RV32M unit.
interface mdu_if #(parameter int XLEN = 32);
    logic            start;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            illegal;

    modport master (output start, funct3, funct7, op_a, op_b,
                    input  busy, done, result, illegal);
    modport slave  (input  start, funct3, funct7, op_a, op_b,
                    output busy, done, result, illegal);
endinterface

// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide unit, one result bit per cycle with start/done handshake.
// Optional build macro MDU_EARLY_OUT_EN: divide-by-zero and signed overflow complete without iterating.
module mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic  clk,
    input  logic  rst,
    mdu_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;
`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [2:0]       f3_q;
    logic             sa_q, sb_q, spc_q, illegal_q;
    logic [XLEN-1:0]  mag_a, mag_b, spc_val_q, hi, lo, result_q;
    logic [CNT_W-1:0] cnt;

    // Request decode
    logic            legal, accept, div_op, a_signed, b_signed, sa_in, sb_in;
    logic            spc_div0, spc_ovf, spc_in;
    logic [XLEN-1:0] mag_a_in, mag_b_in, spc_val_in;

    assign legal    = bus.funct7 == 7'b0000001;
    assign accept   = (state == IDLE) && bus.start && legal;
    assign div_op   = bus.funct3[2];
    assign a_signed = div_op ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01 || bus.funct3[1:0] == 2'b10);
    assign b_signed = div_op ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
    assign sa_in    = a_signed & bus.op_a[XLEN-1];
    assign sb_in    = b_signed & bus.op_b[XLEN-1];
    assign mag_a_in = sa_in ? -bus.op_a : bus.op_a;
    assign mag_b_in = sb_in ? -bus.op_b : bus.op_b;

    assign spc_div0 = div_op && (bus.op_b == '0);
    assign spc_ovf  = div_op && !bus.funct3[0] && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.op_b);
    assign spc_in   = spc_div0 | spc_ovf;
    // funct3[1] selects the remainder flavour of the divide ops
    assign spc_val_in = spc_div0 ? (bus.funct3[1] ? bus.op_a : '1)
                                 : (bus.funct3[1] ? '0 : bus.op_a);

    // One iteration: hi/lo hold the 2*XLEN product, or remainder/quotient when dividing
    logic [XLEN:0]   mul_sum, div_sh, div_diff;
    logic            div_ge;
    logic [XLEN-1:0] step_hi, step_lo;

    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mag_a} : '0);
    assign div_sh   = {hi, lo[XLEN-1]};
    assign div_ge   = div_sh >= {1'b0, mag_b};
    assign div_diff = div_sh - {1'b0, mag_b};

    always_comb begin
        step_hi = mul_sum[XLEN:1];
        step_lo = {mul_sum[0], lo[XLEN-1:1]};
        if (f3_q[2]) begin
            step_hi = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
            step_lo = {lo[XLEN-2:0], div_ge};
        end
    end

    // Sign fix-up and op select on the final iteration's values
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fin;

    assign prod   = {step_hi, step_lo};
    assign prod_s = (sa_q ^ sb_q) ? -prod : prod;
    assign quo_s  = (sa_q ^ sb_q) ? -step_lo : step_lo;
    assign rem_s  = sa_q ? -step_hi : step_hi;

    always_comb begin
        case (f3_q)
            3'b000:        fin = prod_s[XLEN-1:0];
            3'b100, 3'b101: fin = quo_s;
            3'b110, 3'b111: fin = rem_s;
            default:       fin = prod_s[2*XLEN-1:XLEN];
        endcase
        if (spc_q) fin = spc_val_q;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (EARLY && spc_in) ? DONE : RUN;
            RUN:     if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f3_q      <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            spc_q     <= 1'b0;
            spc_val_q <= '0;
            mag_a     <= '0;
            mag_b     <= '0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= (state == IDLE) && bus.start && !legal;
            if (accept) begin
                f3_q      <= bus.funct3;
                sa_q      <= sa_in;
                sb_q      <= sb_in;
                spc_q     <= spc_in;
                spc_val_q <= spc_val_in;
                mag_a     <= mag_a_in;
                mag_b     <= mag_b_in;
                hi        <= '0;
                lo        <= div_op ? mag_a_in : mag_b_in;
                cnt       <= CNT_W'(XLEN - 1);
                if (EARLY && spc_in) result_q <= spc_val_in;
            end else if (state == RUN) begin
                hi  <= step_hi;
                lo  <= step_lo;
                cnt <= cnt - 1'b1;
                if (cnt == '0) result_q <= fin;
            end
        end
    end

    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);
    assign bus.result  = result_q;
    assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq: latency, MUL/DIV families, special cases, abort, illegal.
module tb_mdu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    mdu_if #(.XLEN(32)) bus ();
    mdu_seq #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

`ifdef MDU_EARLY_OUT_EN
    localparam int SPC_LAT = 1;
`else
    localparam int SPC_LAT = 33;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, scramble operands after acceptance, optionally pulse start again at cycle inj.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat, input int inj);
        int k;
        int busy_cnt;
        bus.start = 1'b1; bus.funct7 = 7'b0000001; bus.funct3 = f3; bus.op_a = a; bus.op_b = b;
        tick();
        bus.start = 1'b0; bus.op_a = $urandom; bus.op_b = $urandom;
        k = 1;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && k <= 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (inj != 0 && k == inj) begin
                bus.start = 1'b1; bus.funct3 = 3'b101; bus.op_a = 32'd99; bus.op_b = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            k++;
        end
        bus.start = 1'b0;
        check({tag, " latency"}, k, lat);
        check({tag, " busy cycles"}, busy_cnt, lat - 1);
        check({tag, " result"}, bus.result, exp);
        tick();
        check({tag, " done one-shot"}, {30'd0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.funct3 = '0; bus.funct7 = 7'b0000001; bus.op_a = '0; bus.op_b = '0;
        tick();
        tick();
        check("reset busy/done/illegal", {29'd0, bus.busy, bus.done, bus.illegal}, 32'd0);
        check("reset result", bus.result, 32'd0);
        rst = 1'b0;
        tick();

        run_op("T1 MUL", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
        run_op("T2 MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
        run_op("T2 MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
        run_op("T2 MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
        run_op("T3 DIV", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
        run_op("T3 REM", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
        run_op("T3 DIVU", 3'b101, 32'd100, 32'd7, 32'd14, 33, 0);
        run_op("T3 REMU", 3'b111, 32'd100, 32'd7, 32'd2, 33, 0);

        // T6 illegal funct7: one-cycle pulse, no activity, result held at 2
        bus.start = 1'b1; bus.funct7 = 7'b0000000; bus.funct3 = 3'b000; bus.op_a = 32'd3; bus.op_b = 32'd4;
        tick();
        bus.start = 1'b0; bus.funct7 = 7'b0000001;
        check("T6 illegal pulse", {29'd0, bus.illegal, bus.busy, bus.done}, 32'b100);
        tick();
        check("T6 illegal clear", {29'd0, bus.illegal, bus.busy, bus.done}, 32'b000);
        check("T6 result held", bus.result, 32'd2);

        run_op("T4 DIV0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, SPC_LAT, 0);
        run_op("T4 REM0", 3'b110, 32'd5, 32'd0, 32'd5, SPC_LAT, 0);
        run_op("T4 DIVOVF", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT, 0);
        run_op("T4 REMOVF", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPC_LAT, 0);

        run_op("T5 ignore start", 3'b000, 32'd3, 32'd5, 32'd15, 33, 5);

        // T5 abort: rst sampled at the edge ending cycle 10
        bus.start = 1'b1; bus.funct7 = 7'b0000001; bus.funct3 = 3'b000; bus.op_a = 32'd6; bus.op_b = 32'd7;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        check("T5 busy before rst", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("T5 abort busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
        check("T5 abort result", bus.result, 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
                tick();
            end
            check("T5 no done after abort", seen, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
